// File: rtl/neo_pixel_receiver.sv
// Purpose: WS2812-style single-wire decoder; classifies high-pulse widths into bits and commits a packet on the latch gap.
// Latency: input to synchronized line 2 cycles; commit LATCH_CYCLES+3 cycles after the last falling edge on the line.
// Backpressure: none; the line is free-running and the decoded packet is held in display_packet_o until the next good commit.
module neo_pixel_receiver #(
   parameter int NUM_PIXELS    = 5,
   parameter int BIT_THRESHOLD = 27,
   parameter int MIN_HIGH      = 8,
   parameter int MAX_HIGH      = 60,
   parameter int LATCH_CYCLES  = 2000
) (
   input  logic                         clock_i,
   input  logic                         reset_n_i,
   input  logic                         neo_data_i,
   input  logic [2:0]                   pixel_index_i,
   input  logic [1:0]                   color_index_i,
   output logic [7:0]                   color_level_o,
   output logic [24*NUM_PIXELS-1:0]     display_packet_o,
   output logic                         frame_valid_o,
   output logic                         frame_error_o,
   output logic                         busy_o,
   output logic [6:0]                   bit_count_o
);

   localparam int NUM_BITS = 24 * NUM_PIXELS;

   localparam logic [1:0] ST_SYNC = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_HIGH = 2'd2;
   localparam logic [1:0] ST_LOW  = 2'd3;

   localparam logic [6:0]  THR_CNT   = 7'(BIT_THRESHOLD);
   localparam logic [6:0]  MIN_CNT   = 7'(MIN_HIGH);
   localparam logic [6:0]  MAX_CNT   = 7'(MAX_HIGH);
   localparam logic [6:0]  NB_CNT    = 7'(NUM_BITS);
   localparam logic [11:0] LATCH_CNT = 12'(LATCH_CYCLES);

   logic                sync1_q;
   logic                s_q;
   logic [1:0]          state_q, state_d;
   logic [6:0]          hi_cnt_q, hi_cnt_d;
   logic [11:0]         lo_cnt_q, lo_cnt_d;
   logic [6:0]          bit_cnt_q, bit_cnt_d;
   logic [NUM_BITS-1:0] shadow_q, shadow_d;
   logic [NUM_BITS-1:0] disp_q, disp_d;
   logic                fv_q, fv_d;
   logic                fe_q, fe_d;
   logic [6:0]          hi_inc;
   logic [11:0]         lo_inc;
   logic [6:0]          bit_inc;
   logic [7:0]          color_lvl;

   // Saturating increments shared by every state.
   always_comb begin
      hi_inc  = (hi_cnt_q  == 7'h7F)   ? hi_cnt_q  : hi_cnt_q  + 7'd1;
      lo_inc  = (lo_cnt_q  == 12'hFFF) ? lo_cnt_q  : lo_cnt_q  + 12'd1;
      bit_inc = (bit_cnt_q == 7'h7F)   ? bit_cnt_q : bit_cnt_q + 7'd1;
   end

   // Decode FSM. The high counter is loaded with 1 on a rise because the rise
   // sample is itself the first high cycle, so a W-cycle pulse measures W.
   always_comb begin
      state_d   = state_q;
      hi_cnt_d  = hi_cnt_q;
      lo_cnt_d  = lo_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shadow_d  = shadow_q;
      disp_d    = disp_q;
      fv_d      = 1'b0;
      fe_d      = 1'b0;
      case (state_q)
         ST_SYNC: begin
            if (s_q) begin
               lo_cnt_d = '0;
            end else begin
               lo_cnt_d = lo_inc;
               if (lo_inc == LATCH_CNT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_IDLE: begin
            if (s_q) begin
               bit_cnt_d = '0;
               hi_cnt_d  = 7'd1;
               state_d   = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (s_q) begin
               hi_cnt_d = hi_inc;
               if (hi_inc > MAX_CNT) begin
                  fe_d     = 1'b1;
                  lo_cnt_d = '0;
                  state_d  = ST_SYNC;
               end
            end else if (hi_cnt_q < MIN_CNT) begin
               fe_d     = 1'b1;
               lo_cnt_d = '0;
               state_d  = ST_SYNC;
            end else begin
               // Bits past the packet length are counted but not stored.
               if (bit_cnt_q < NB_CNT) begin
                  shadow_d[bit_cnt_q] = (hi_cnt_q >= THR_CNT);
               end
               bit_cnt_d = bit_inc;
               lo_cnt_d  = '0;
               state_d   = ST_LOW;
            end
         end
         ST_LOW: begin
            lo_cnt_d = lo_inc;
            // Latch takes priority over a rise landing on the same cycle.
            if (lo_inc == LATCH_CNT) begin
               state_d = ST_IDLE;
               if (bit_cnt_q == NB_CNT) begin
                  disp_d = shadow_q;
                  fv_d   = 1'b1;
               end else begin
                  fe_d = 1'b1;
               end
            end else if (s_q) begin
               hi_cnt_d = 7'd1;
               state_d  = ST_HIGH;
            end
         end
      endcase
   end

   // Two-flop synchronizer plus all decoder state.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q   <= 1'b0;
         s_q       <= 1'b0;
         state_q   <= ST_SYNC;
         hi_cnt_q  <= '0;
         lo_cnt_q  <= '0;
         bit_cnt_q <= '0;
         shadow_q  <= '0;
         disp_q    <= '0;
         fv_q      <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         sync1_q   <= neo_data_i;
         s_q       <= sync1_q;
         state_q   <= state_d;
         hi_cnt_q  <= hi_cnt_d;
         lo_cnt_q  <= lo_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         fv_q      <= fv_d;
         fe_q      <= fe_d;
      end
   end

   // Combinational readback: R/B/G byte of the selected pixel, zero when out of range.
   always_comb begin
      color_lvl = '0;
      for (int p = 0; p < NUM_PIXELS; p++) begin
         if (pixel_index_i == 3'(p)) begin
            case (color_index_i)
               2'b00:   color_lvl = disp_q[24*p+8  +: 8];
               2'b01:   color_lvl = disp_q[24*p    +: 8];
               2'b10:   color_lvl = disp_q[24*p+16 +: 8];
               default: color_lvl = '0;
            endcase
         end
      end
   end

   assign color_level_o    = color_lvl;
   assign display_packet_o = disp_q;
   assign frame_valid_o    = fv_q;
   assign frame_error_o    = fe_q;
   assign busy_o           = (state_q == ST_HIGH) || (state_q == ST_LOW);
   assign bit_count_o      = bit_cnt_q;

endmodule

// File: tb/tb_neo_pixel_receiver.sv
// Bench for neo_pixel_receiver: random pulse trains against an event-schedule model.
// Expected commit/error cycles are derived from line-edge times; packet contents from the bits sent.
// Readback indices are randomized every cycle and checked against the model packet.
module tb_neo_pixel_receiver;
   localparam int NP    = 5;
   localparam int NB    = 120;
   localparam int LATCH = 2000;
   localparam int MAXH  = 60;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          nd    = 1'b0;
   logic [2:0]    pix   = '0;
   logic [1:0]    col   = '0;
   logic [7:0]    color_level;
   logic [NB-1:0] display_packet;
   logic          frame_valid, frame_error, busy;
   logic [6:0]    bit_count;

   neo_pixel_receiver dut (
      .clock_i          (clk),
      .reset_n_i        (rst_n),
      .neo_data_i       (nd),
      .pixel_index_i    (pix),
      .color_index_i    (col),
      .color_level_o    (color_level),
      .display_packet_o (display_packet),
      .frame_valid_o    (frame_valid),
      .frame_error_o    (frame_error),
      .busy_o           (busy),
      .bit_count_o      (bit_count)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;
   int nvalid = 0, nerr = 0;
   bit ev_valid[int];
   bit ev_err[int];
   logic [NB-1:0] ev_pkt[int];
   logic [NB-1:0] model_disp = '0;
   bit idx_rand = 1'b1;

   function automatic logic [7:0] rb(input logic [NB-1:0] pkt, input logic [2:0] p, input logic [1:0] c);
      int base;
      if (int'(p) >= NP || c == 2'b11) return 8'h00;
      base = 24 * int'(p);
      case (c)
         2'b00:   return pkt[base+8 +: 8];
         2'b01:   return pkt[base +: 8];
         default: return pkt[base+16 +: 8];
      endcase
   endfunction

   task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the event schedule.
   always @(negedge clk) begin
      logic exp_fv, exp_fe;
      exp_fv = rst_n && ev_valid.exists(cyc);
      exp_fe = rst_n && ev_err.exists(cyc);
      if (!rst_n) model_disp = '0;
      else if (exp_fv) model_disp = ev_pkt[cyc];
      if (frame_valid) nvalid++;
      if (frame_error) nerr++;
      chk("frame_valid", NB'(frame_valid), NB'(exp_fv));
      chk("frame_error", NB'(frame_error), NB'(exp_fe));
      chk("display_packet", display_packet, model_disp);
      chk("color_level", NB'(color_level), NB'(rb(model_disp, pix, col)));
      if (exp_fv || exp_fe) chk("busy_at_frame_end", NB'(busy), '0);
   end

   // Random readback selection, including out-of-range pixels and the reserved color.
   initial forever begin
      @(posedge clk);
      #2;
      if (idx_rand) begin
         pix = 3'($urandom_range(7, 0));
         col = 2'($urandom_range(3, 0));
      end
   end

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      nd = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mode 0 random timing, 1 fixed controller timing, 2 threshold pulses on bits 0/1,
   // 3 first pulse one cycle longer (its first cycle is swallowed by a coincident latch).
   // outcome 0 none, 1 commit at latch, 2 error at latch.
   task automatic send_packet(input logic [NB-1:0] pkt, input int nbits, input int mode,
                              input int gap, input int outcome);
      int h, l, tf;
      logic b;
      for (int i = 0; i < nbits; i++) begin
         b = pkt[i];
         if (mode == 1) begin
            h = b ? 35 : 18;
            l = b ? 30 : 40;
         end else begin
            h = b ? int'($urandom_range(60, 27)) : int'($urandom_range(26, 8));
            l = int'($urandom_range(16, 4));
         end
         if (mode == 2 && i == 0) h = 26;
         if (mode == 2 && i == 1) h = 27;
         if (mode == 3 && i == 0) h = b ? int'($urandom_range(60, 28)) : int'($urandom_range(26, 9));
         drive(1'b1, h);
         tf = cyc;
         if (i == nbits - 1) begin
            l = gap;
            if (outcome == 1) begin
               ev_valid[tf+3+LATCH] = 1'b1;
               ev_pkt[tf+3+LATCH]   = pkt;
            end else if (outcome == 2) begin
               ev_err[tf+3+LATCH] = 1'b1;
            end
         end
         drive(1'b0, l);
      end
   endtask

   function automatic logic [NB-1:0] rnd_pkt();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[NB-1:0];
   endfunction

   initial begin
      logic [NB-1:0] p1, p2, p3, p4, pa, pb, pf, q1, q2, q3;
      int t;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_display", display_packet, '0);
      chk("reset_bit_count", NB'(bit_count), '0);
      chk("reset_busy", NB'(busy), '0);
      rst_n = 1'b1;

      // Single red pixel with controller timing.
      drive(1'b0, 2010);
      p1 = '0;
      p1[63:56] = 8'hA5;
      send_packet(p1, 120, 1, 2500, 1);
      idx_rand = 1'b0;
      for (int p = 0; p < 8; p++) begin
         for (int c = 0; c < 4; c++) begin
            pix = 3'(p);
            col = 2'(c);
            #1;
            chk("t1_readback", NB'(color_level), NB'((p == 2 && c == 0) ? 8'hA5 : 8'h00));
         end
      end
      idx_rand = 1'b1;
      realign();
      chk("t1_bit_count", NB'(bit_count), NB'(7'd120));
      chk("t1_display", display_packet, NB'(64'hA5) << 56);

      // Short packet: error at latch, display unchanged.
      p3 = rnd_pkt();
      send_packet(p3, 119, 0, LATCH + 20, 2);
      chk("t3_display_kept", display_packet, NB'(64'hA5) << 56);
      chk("t3_bit_count", NB'(bit_count), NB'(7'd119));

      // Threshold boundary: 26 cycles decodes 0, 27 decodes 1.
      p2 = '0;
      p2[1] = 1'b1;
      send_packet(p2, 120, 2, LATCH + 20, 1);
      idx_rand = 1'b0;
      pix = 3'd0;
      col = 2'b01;
      #1;
      chk("t2_pixel0_blue", NB'(color_level), NB'(8'h02));
      chk("t2_display", display_packet, NB'(2));
      idx_rand = 1'b1;
      realign();

      // Glitch shorter than the minimum width.
      drive(1'b1, 7);
      ev_err[cyc+3] = 1'b1;
      drive(1'b0, LATCH + 20);

      // Stuck-high pulse mid-packet, then a full packet after a fresh gap.
      pa = rnd_pkt();
      send_packet(pa, 30, 0, 10, 0);
      ev_err[cyc+3+MAXH] = 1'b1;
      drive(1'b1, 70);
      drive(1'b0, LATCH + 10);
      chk("t4_bit_count", NB'(bit_count), NB'(7'd30));
      chk("t4_busy", NB'(busy), '0);
      p4 = rnd_pkt();
      send_packet(p4, 120, 0, LATCH + 20, 1);

      // Reset mid-packet.
      pb = rnd_pkt();
      send_packet(pb, 60, 0, 10, 0);
      rst_n = 1'b0;
      #1;
      chk("t5_reset_display", display_packet, '0);
      chk("t5_reset_bit_count", NB'(bit_count), '0);
      chk("t5_reset_busy", NB'(busy), '0);
      chk("t5_reset_color", NB'(color_level), '0);
      realign();
      repeat (3) realign();
      rst_n = 1'b1;
      drive(1'b0, LATCH + 10);
      pf = '1;
      send_packet(pf, 120, 0, LATCH + 20, 1);
      idx_rand = 1'b0;
      for (int p = 0; p < NP; p++) begin
         for (int c = 0; c < 3; c++) begin
            pix = 3'(p);
            col = 2'(c);
            #1;
            chk("t5_readback_ff", NB'(color_level), NB'(8'hFF));
         end
      end
      idx_rand = 1'b1;
      realign();

      // Back-to-back packets; the second starts on the exact latch cycle.
      q1 = rnd_pkt();
      q2 = rnd_pkt();
      q3 = rnd_pkt();
      send_packet(q1, 120, 0, LATCH, 1);
      send_packet(q2, 120, 3, LATCH + 1, 1);
      send_packet(q3, 120, 0, LATCH + 20, 1);
      chk("t6_bit_count", NB'(bit_count), NB'(7'd120));

      chk("total_frame_valid", NB'(nvalid), NB'(7));
      chk("total_frame_error", NB'(nerr), NB'(3));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
